dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_if.sv | 42 ++++
 rtl/dispatch_queue.sv | 77 +++++++
 tb/tb_dispatch_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: fetch-side, dispatch-side and core-feedback signals of the dispatch queue.
interface dispatch_queue_if #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = 32
);
  localparam int NW = $clog2(N_WAY) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [N_WAY-1:0] fetch_valid;
  logic [N_WAY-1:0][XLEN-1:0] fetch_inst;
  logic [N_WAY-1:0][XLEN-1:0] fetch_pc;
  logic [N_WAY-1:0][XLEN-1:0] fetch_npc;
  logic [N_WAY-1:0][4:0] fetch_src1;
  logic [N_WAY-1:0][4:0] fetch_src2;
  logic [N_WAY-1:0][4:0] fetch_dest;
  logic [N_WAY-1:0] fetch_branch;
  logic [NW-1:0] fetch_accept_num;
  logic [CW-1:0] free_slots;
  logic [N_WAY-1:0] disp_valid;
  logic [N_WAY-1:0][XLEN-1:0] disp_inst;
  logic [N_WAY-1:0][XLEN-1:0] disp_pc;
  logic [N_WAY-1:0][XLEN-1:0] disp_npc;
  logic [N_WAY-1:0][4:0] disp_src1;
  logic [N_WAY-1:0][4:0] disp_src2;
  logic [N_WAY-1:0][4:0] disp_dest;
  logic [N_WAY-1:0] disp_branch;
  logic [N_WAY-1:0] dispatched;
  logic branch_haz;
  logic [15:0] stall_cycles;
  modport slave (
    input fetch_valid, fetch_inst, fetch_pc, fetch_npc, fetch_src1, fetch_src2, fetch_dest, fetch_branch,
    input dispatched, branch_haz,
    output fetch_accept_num, free_slots, stall_cycles,
    output disp_valid, disp_inst, disp_pc, disp_npc, disp_src1, disp_src2, disp_dest, disp_branch
  );
  modport master (
    output fetch_valid, fetch_inst, fetch_pc, fetch_npc, fetch_src1, fetch_src2, fetch_dest, fetch_branch,
    output dispatched, branch_haz,
    input fetch_accept_num, free_slots, stall_cycles,
    input disp_valid, disp_inst, disp_pc, disp_npc, disp_src1, disp_src2, disp_dest, disp_branch
  );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue: N-way circular buffer between fetch and the rename/ROB/RS core, with flush and stall count.
module dispatch_queue #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = 32
) (
  input logic clock,
  input logic reset,
  dispatch_queue_if.slave dq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(N_WAY) + 1;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dest;
    logic branch;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t lane [N_WAY];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, free, pop_num, lead, accept;
  logic [15:0] stall;
  assign free = CW'(DEPTH) - count;
  // pop_num/lead only grow while every earlier lane qualified, giving the leading-ones prefix
  always_comb begin
    pop_num = '0;
    lead = '0;
    for (int i = 0; i < N_WAY; i++) begin
      lane[i] = CW'(i) < count ? mem[head + AW'(i)] : '0;
      if (CW'(i) < count && dq.dispatched[i] && pop_num == CW'(i)) pop_num = pop_num + CW'(1);
      if (dq.fetch_valid[i] && lead == CW'(i)) lead = lead + CW'(1);
    end
    accept = (reset || dq.branch_haz) ? '0 : (lead < free ? lead : free);
  end
  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      dq.disp_valid[i] = CW'(i) < count;
      dq.disp_inst[i] = lane[i].inst;
      dq.disp_pc[i] = lane[i].pc;
      dq.disp_npc[i] = lane[i].npc;
      dq.disp_src1[i] = lane[i].src1;
      dq.disp_src2[i] = lane[i].src2;
      dq.disp_dest[i] = lane[i].dest;
      dq.disp_branch[i] = lane[i].branch;
    end
  end
  assign dq.free_slots = free;
  assign dq.fetch_accept_num = accept[NW-1:0];
  assign dq.stall_cycles = stall;
  always_ff @(posedge clock)
    for (int i = 0; i < N_WAY; i++)
      if (CW'(i) < accept)
        mem[tail + AW'(i)] <= '{inst: dq.fetch_inst[i], pc: dq.fetch_pc[i], npc: dq.fetch_npc[i],
                                src1: dq.fetch_src1[i], src2: dq.fetch_src2[i], dest: dq.fetch_dest[i],
                                branch: dq.fetch_branch[i]};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      stall <= '0;
    end else if (dq.branch_haz) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(pop_num);
      tail <= tail + AW'(accept);
      count <= count + accept - pop_num;
      if (count != '0 && pop_num == '0 && stall != 16'hFFFF) stall <= stall + 16'd1;
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: queue-based reference model checked every cycle, plus directed literal expectations.
module tb_dispatch_queue;
  localparam int N = 2;
  localparam int D = 8;
  localparam int X = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  dispatch_queue_if #(.N_WAY(N), .DEPTH(D), .XLEN(X)) dq ();
  dispatch_queue #(.N_WAY(N), .DEPTH(D), .XLEN(X)) dut (.clock(clock), .reset(reset), .dq(dq));
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] d;
    logic br;
  } ent_t;
  ent_t q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] fetch_base = 32'd0;
  logic [15:0] m_stall = 16'd0;
  int m_n, m_pop, m_lead, m_acc;
  logic [N-1:0] ev, ebr;
  logic [N*32-1:0] epc, einst, enpc;
  logic [N*5-1:0] es1, es2, ed;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc = pc;
    e.inst = pc ^ 32'h1357_9BDF;
    e.br = pc[3];
    e.npc = e.br ? pc + 32'h40 : pc + 32'h4;
    e.s1 = pc[6:2];
    e.s2 = ~pc[6:2];
    e.d = pc[6:2] + 5'd1;
    return e;
  endfunction
  // Model: the buffer is a plain queue; outputs follow from its size and the inputs of this cycle
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      m_stall = 16'd0;
      fetch_base = 32'd0;
      chk("rst_valid", 64'(dq.disp_valid), 64'd0);
      chk("rst_free", 64'(dq.free_slots), 64'(D));
      chk("rst_accept", 64'(dq.fetch_accept_num), 64'd0);
      chk("rst_stall", 64'(dq.stall_cycles), 64'd0);
    end else begin
      m_n = q.size();
      ev = '0; ebr = '0; epc = '0; einst = '0; enpc = '0; es1 = '0; es2 = '0; ed = '0;
      for (int i = 0; i < N; i++)
        if (i < m_n) begin
          ev[i] = 1'b1;
          epc[i*32 +: 32] = q[i].pc;
          einst[i*32 +: 32] = q[i].inst;
          enpc[i*32 +: 32] = q[i].npc;
          es1[i*5 +: 5] = q[i].s1;
          es2[i*5 +: 5] = q[i].s2;
          ed[i*5 +: 5] = q[i].d;
          ebr[i] = q[i].br;
        end
      m_pop = 0;
      while (m_pop < N && m_pop < m_n && dq.dispatched[m_pop]) m_pop++;
      m_lead = 0;
      while (m_lead < N && dq.fetch_valid[m_lead]) m_lead++;
      m_acc = dq.branch_haz ? 0 : (m_lead < D - m_n ? m_lead : D - m_n);
      chk("m_valid", 64'(dq.disp_valid), 64'(ev));
      chk("m_pc", 64'(dq.disp_pc), 64'(epc));
      chk("m_inst", 64'(dq.disp_inst), 64'(einst));
      chk("m_npc", 64'(dq.disp_npc), 64'(enpc));
      chk("m_regs", 64'({dq.disp_src1, dq.disp_src2, dq.disp_dest, dq.disp_branch}), 64'({es1, es2, ed, ebr}));
      chk("m_free", 64'(dq.free_slots), 64'(D - m_n));
      chk("m_accept", 64'(dq.fetch_accept_num), 64'(m_acc));
      chk("m_stall", 64'(dq.stall_cycles), 64'(m_stall));
      if (dq.branch_haz) begin
        q.delete();
        fetch_base = 32'd0;
      end else begin
        if (m_n > 0 && m_pop == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        for (int i = 0; i < m_pop; i++) void'(q.pop_front());
        for (int i = 0; i < m_acc; i++)
          q.push_back('{inst: dq.fetch_inst[i], pc: dq.fetch_pc[i], npc: dq.fetch_npc[i],
                        s1: dq.fetch_src1[i], s2: dq.fetch_src2[i], d: dq.fetch_dest[i], br: dq.fetch_branch[i]});
        fetch_base = fetch_base + 32'(4 * m_acc);
      end
    end
  end
  task automatic apply(input logic [N-1:0] fv, input logic [N-1:0] dsp, input logic bh);
    ent_t e;
    dq.fetch_valid = fv;
    dq.dispatched = dsp;
    dq.branch_haz = bh;
    for (int i = 0; i < N; i++) begin
      e = mk(fetch_base + 32'(4 * i));
      dq.fetch_pc[i] = e.pc;
      dq.fetch_inst[i] = e.inst;
      dq.fetch_npc[i] = e.npc;
      dq.fetch_src1[i] = e.s1;
      dq.fetch_src2[i] = e.s2;
      dq.fetch_dest[i] = e.d;
      dq.fetch_branch[i] = e.br;
    end
    #2;
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  logic [N-1:0] fvt [5] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b11};
  logic [N-1:0] dst [7] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01};
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end
  initial begin
    apply(2'b11, 2'b00, 1'b0);
    tick;
    tick;
    chk("lit_rst_free", 64'(dq.free_slots), 64'd8);
    chk("lit_rst_accept", 64'(dq.fetch_accept_num), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply(2'b11, 2'b00, 1'b0);
      chk("lit_fill_accept", 64'(dq.fetch_accept_num), 64'd2);
      tick;
    end
    chk("lit_full_free", 64'(dq.free_slots), 64'd0);
    chk("lit_fill_pc", 64'(dq.disp_pc), {32'h4, 32'h0});
    chk("lit_stall3", 64'(dq.stall_cycles), 64'd3);
    apply(2'b11, 2'b00, 1'b0);
    chk("lit_full_accept", 64'(dq.fetch_accept_num), 64'd0);
    tick;
    chk("lit_stall4", 64'(dq.stall_cycles), 64'd4);
    apply(2'b11, 2'b11, 1'b0);
    chk("lit_simul_accept", 64'(dq.fetch_accept_num), 64'd0);
    tick;
    chk("lit_simul_free", 64'(dq.free_slots), 64'd2);
    chk("lit_simul_pc", 64'(dq.disp_pc), {32'hC, 32'h8});
    apply(2'b11, 2'b00, 1'b0);
    chk("lit_after_accept", 64'(dq.fetch_accept_num), 64'd2);
    tick;
    apply(2'b00, 2'b11, 1'b0);
    tick;
    apply(2'b00, 2'b11, 1'b0);
    tick;
    apply(2'b00, 2'b01, 1'b0);
    tick;
    chk("lit_cnt3_free", 64'(dq.free_slots), 64'd5);
    chk("lit_cnt3_pc", 64'(dq.disp_pc), {32'h20, 32'h1C});
    apply(2'b00, 2'b10, 1'b0);
    tick;
    chk("lit_gap_free", 64'(dq.free_slots), 64'd5);
    apply(2'b00, 2'b01, 1'b0);
    tick;
    chk("lit_ack0_free", 64'(dq.free_slots), 64'd6);
    chk("lit_ack0_pc", 64'(dq.disp_pc[0]), 64'h20);
    apply(2'b11, 2'b00, 1'b0);
    tick;
    apply(2'b01, 2'b00, 1'b0);
    tick;
    chk("lit_cnt5_free", 64'(dq.free_slots), 64'd3);
    apply(2'b11, 2'b00, 1'b1);
    chk("lit_flush_accept", 64'(dq.fetch_accept_num), 64'd0);
    tick;
    chk("lit_flush_valid", 64'(dq.disp_valid), 64'd0);
    chk("lit_flush_free", 64'(dq.free_slots), 64'd8);
    apply(2'b11, 2'b00, 1'b0);
    tick;
    chk("lit_post_flush_pc", 64'(dq.disp_pc), {32'h4, 32'h0});
    apply(2'b00, 2'b00, 1'b1);
    tick;
    for (int k = 0; k < 12; k++) begin
      apply(2'b11, 2'b11, 1'b0);
      if (k > 0) chk("lit_wrap_pc", 64'(dq.disp_pc), {32'(8 * (k - 1) + 4), 32'(8 * (k - 1))});
      tick;
    end
    for (int i = 0; i < 40; i++) begin
      apply(fvt[i % 5], dst[i % 7], i % 17 == 16);
      tick;
    end
    apply(2'b00, 2'b00, 1'b1);
    tick;
    apply(2'b11, 2'b00, 1'b0);
    tick;
    tick;
    chk("lit_cnt4_free", 64'(dq.free_slots), 64'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("lit_async_valid", 64'(dq.disp_valid), 64'd0);
    chk("lit_async_free", 64'(dq.free_slots), 64'd8);
    chk("lit_async_accept", 64'(dq.fetch_accept_num), 64'd0);
    tick;
    reset = 1'b0;
    apply(2'b00, 2'b00, 1'b0);
    tick;
    chk("lit_post_rst_valid", 64'(dq.disp_valid), 64'd0);
    chk("lit_post_rst_free", 64'(dq.free_slots), 64'd8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
